// File: rtl/demux_1xn_gather.sv
// demux_1xn_gather
//   Gathers consecutive valid input symbols into LANES parallel slots and
//   emits the assembled word with a one-cycle strobe. A partially filled
//   word is released by an explicit flush or after TIMEOUT idle cycles,
//   with a per-lane valid mask telling which lanes hold received symbols.
//
// Parameters
//   WIDTH    bits per symbol (per lane)
//   LANES    number of output lanes, power of two, >= 2
//   TIMEOUT  idle cycles in FILL before a partial word is auto-emitted; 0 disables
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   data_in     input symbol
//   valid_in    data_in valid this cycle
//   flush       emit any held symbols as a partial word
//   data_out    assembled word, lane j at [j*WIDTH +: WIDTH], unfilled lanes are 0
//   lane_valid  bit j set if lane j of data_out holds a received symbol
//   out_strobe  one-cycle pulse when data_out/lane_valid were updated
//   partial     emitted word had fewer than LANES symbols (held until next emission)
//   busy        at least one symbol held (state FILL)
module demux_1xn_gather #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     valid_in,
    input  logic                     flush,
    output logic [LANES*WIDTH-1:0]   data_out,
    output logic [LANES-1:0]         lane_valid,
    output logic                     out_strobe,
    output logic                     partial,
    output logic                     busy
);

    localparam int unsigned PW    = $clog2(LANES);
    localparam bit          TO_EN = (TIMEOUT > 0);
    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned CW    = TO_EN ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(LANES - 1);
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [PW-1:0]                 ptr_q, ptr_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [LANES-1:0][WIDTH-1:0]   bank_q, bank_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic [LANES*WIDTH-1:0]        data_out_q, data_out_d;
    logic [LANES-1:0]              lane_valid_q, lane_valid_d;
    logic                          out_strobe_q, out_strobe_d;
    logic                          partial_q, partial_d;

    logic full_word;
    logic flush_emit;
    logic timeout_emit;
    logic emit;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        bank_d       = bank_q;
        mask_d       = mask_q;
        data_out_d   = data_out_q;
        lane_valid_d = lane_valid_q;
        out_strobe_d = 1'b0;
        partial_d    = partial_q;

        full_word    = 1'b0;
        flush_emit   = 1'b0;
        timeout_emit = 1'b0;

        // Store first; every later decision looks at the updated bank/mask.
        if (valid_in) begin
            bank_d[ptr_q] = data_in;
            mask_d[ptr_q] = 1'b1;
            cnt_d         = '0;
            full_word     = (ptr_q == PTR_LAST);
        end

        flush_emit = flush && (|mask_d);

        if (TO_EN && (state_q == FILL) && !valid_in && !flush) begin
            if (cnt_q == CNT_LAST) begin
                timeout_emit = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        emit = full_word || flush_emit || timeout_emit;

        if (emit) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                data_out_d[j*WIDTH +: WIDTH] = mask_d[j] ? bank_d[j] : '0;
            end
            lane_valid_d = mask_d;
            partial_d    = ~(&mask_d);
            out_strobe_d = 1'b1;
            ptr_d        = '0;
            mask_d       = '0;
            cnt_d        = '0;
            state_d      = IDLE;
        end else if (valid_in) begin
            ptr_d   = ptr_q + PW'(1);
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            bank_q       <= '0;
            mask_q       <= '0;
            data_out_q   <= '0;
            lane_valid_q <= '0;
            out_strobe_q <= 1'b0;
            partial_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            bank_q       <= bank_d;
            mask_q       <= mask_d;
            data_out_q   <= data_out_d;
            lane_valid_q <= lane_valid_d;
            out_strobe_q <= out_strobe_d;
            partial_q    <= partial_d;
        end
    end

    assign data_out   = data_out_q;
    assign lane_valid = lane_valid_q;
    assign out_strobe = out_strobe_q;
    assign partial    = partial_q;
    assign busy       = (state_q == FILL);

endmodule

// File: tb/tb_demux_1xn_gather.sv
// tb_demux_1xn_gather
//   Directed bench for demux_1xn_gather with WIDTH=8, LANES=4, TIMEOUT=8.
module tb_demux_1xn_gather;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        flush;
    logic [31:0] data_out;
    logic [3:0]  lane_valid;
    logic        out_strobe;
    logic        partial;
    logic        busy;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned fails  = 0;

    demux_1xn_gather #(
        .WIDTH   (8),
        .LANES   (4),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .flush      (flush),
        .data_out   (data_out),
        .lane_valid (lane_valid),
        .out_strobe (out_strobe),
        .partial    (partial),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle 1 time unit after it.
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        valid_in = v;
        data_in  = d;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic [3:0] lv,
                              input logic p);
        check({tag, "_strobe"}, {31'd0, out_strobe}, 32'd1);
        check({tag, "_data"}, data_out, d);
        check({tag, "_lv"}, {28'd0, lane_valid}, {28'd0, lv});
        check({tag, "_partial"}, {31'd0, partial}, {31'd0, p});
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        flush    = 1'b0;
        #12;
        check("rst_data", data_out, 32'h0);
        check("rst_lv", {28'd0, lane_valid}, 32'h0);
        check("rst_strobe", {31'd0, out_strobe}, 32'h0);
        check("rst_partial", {31'd0, partial}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Two back-to-back full words
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0);
            if (i == 3) check_word("full1", 32'h13121110, 4'hF, 1'b0);
            else if (i == 7) check_word("full2", 32'h17161514, 4'hF, 1'b0);
            else check("full_nostrobe", {31'd0, out_strobe}, 32'h0);
        end
        step(1'b0, 8'h00, 1'b0);
        check("full_idle_strobe", {31'd0, out_strobe}, 32'h0);
        check("full_idle_busy", {31'd0, busy}, 32'h0);
        check("full_hold_data", data_out, 32'h17161514);

        // Partial flush
        step(1'b1, 8'hA0, 1'b0);
        check("fl_busy", {31'd0, busy}, 32'h1);
        step(1'b1, 8'hA1, 1'b0);
        check("fl_nostrobe", {31'd0, out_strobe}, 32'h0);
        step(1'b0, 8'h00, 1'b1);
        check_word("flush", 32'h0000A1A0, 4'h3, 1'b1);
        check("flush_busy", {31'd0, busy}, 32'h0);
        step(1'b0, 8'h00, 1'b0);
        check("flush_single", {31'd0, out_strobe}, 32'h0);
        check("flush_hold_partial", {31'd0, partial}, 32'h1);

        // Flush together with the completing symbol
        step(1'b1, 8'hD0, 1'b0);
        step(1'b1, 8'hD1, 1'b0);
        step(1'b1, 8'hD2, 1'b0);
        check("d_nostrobe", {31'd0, out_strobe}, 32'h0);
        step(1'b1, 8'hD3, 1'b1);
        check_word("flushfull", 32'hD3D2D1D0, 4'hF, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("flushfull_single", {31'd0, out_strobe}, 32'h0);

        // Timeout after a single symbol
        step(1'b1, 8'h55, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("to_nostrobe", {31'd0, out_strobe}, 32'h0);
        end
        check("to_busy7", {31'd0, busy}, 32'h1);
        step(1'b0, 8'h00, 1'b0);
        check_word("timeout", 32'h00000055, 4'h1, 1'b1);
        check("timeout_busy", {31'd0, busy}, 32'h0);

        // Symbol on idle cycle 7 restarts the timer
        step(1'b1, 8'h66, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h67, 1'b0);
        check("rs_cycle7_strobe", {31'd0, out_strobe}, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (i < 8) check("rs_nostrobe", {31'd0, out_strobe}, 32'h0);
            else check_word("rs_timeout", 32'h00006766, 4'h3, 1'b1);
        end

        // Asynchronous reset mid-word
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b0);
        valid_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_data", data_out, 32'h0);
        check("arst_lv", {28'd0, lane_valid}, 32'h0);
        check("arst_partial", {31'd0, partial}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        check("arst_strobe", {31'd0, out_strobe}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i < 4) check("post_nostrobe", {31'd0, out_strobe}, 32'h0);
        end
        check_word("post_rst", 32'h04030201, 4'hF, 1'b0);

        // Flush while IDLE does nothing
        step(1'b0, 8'h00, 1'b1);
        check("idleflush_strobe", {31'd0, out_strobe}, 32'h0);
        check("idleflush_data", data_out, 32'h04030201);
        check("idleflush_lv", {28'd0, lane_valid}, 32'hF);
        check("idleflush_partial", {31'd0, partial}, 32'h0);
        check("idleflush_busy", {31'd0, busy}, 32'h0);
        step(1'b0, 8'h00, 1'b0);
        check("idleflush_after", {31'd0, out_strobe}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demux_1xn_gather.md
# demux_1xn_gather

Parametrised byte-to-lane gatherer for the PHY receive path. It generalises the fixed 1x4 byte demultiplexer: one clock instead of divided clocks, any power-of-two lane count and any data width. It collects consecutive valid input symbols into LANES parallel slots and emits the assembled word with a one-cycle strobe. Partially filled words are released by explicit flush or by an idle timeout, with a per-lane valid mask.

## Interface
- WIDTH, 8: bits per symbol (per lane).
- LANES, 4: number of output lanes; a power of two, at least 2.
- TIMEOUT, 8: idle cycles in FILL before a partial word is auto-emitted; 0 disables the timeout.

- clk  input  1  Single clock; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-low reset.
- data_in  input  WIDTH  Input symbol.
- valid_in  input  1  data_in is valid this cycle; sampled on the rising clk edge.
- flush  input  1  Emit any held symbols as a partial word.
- data_out  output  LANES*WIDTH  Assembled word; lane j occupies bits [j*WIDTH +: WIDTH].
- lane_valid  output  LANES  Bit j set if lane j of data_out holds a received symbol.
- out_strobe  output  1  One-cycle pulse: data_out and lane_valid were updated at this edge.
- partial  output  1  Qualifies out_strobe: the emitted word has fewer than LANES symbols. Holds until the next emission.
- busy  output  1  High while in FILL (at least one symbol held).

## Operation
- Internal state:
  - write pointer ptr, width clog2(LANES).
  - hold bank of LANES x WIDTH bits, plus its hold-valid mask.
  - idle counter, width clog2(TIMEOUT+1).
  - FSM with states IDLE and FILL.
- IDLE: ptr=0 and the hold mask is empty.
  - valid_in=1: store data_in in slot 0, set ptr=1, move to FILL.
  - valid_in=0 and flush=1: no action and no strobe.
- FILL, on valid_in=1:
  - Store data_in in slot ptr and set its hold-valid bit.
  - Clear the idle counter.
  - If ptr was LANES-1: emit a full word (lane_valid all ones, partial=0), set ptr=0, go to IDLE.
  - Otherwise ptr increments.
- FILL, on flush=1:
  - If valid_in is also 1, that symbol is stored first, then the word is emitted.
  - partial=1 unless the word became full that cycle.
  - After emission: ptr=0, hold mask cleared, state IDLE.
- FILL, idle timeout (TIMEOUT>0):
  - Each cycle with valid_in=0 and flush=0, the idle counter increments.
  - On the edge where the counter would reach TIMEOUT, emit a partial word, clear the counter, go to IDLE.
- Priority within one cycle: valid_in store, then full-word emission, then flush, then timeout.
  - valid_in=1 always clears the counter, so a timeout never fires in a cycle with valid_in=1.
- Emission:
  - The hold bank and mask are copied to data_out and lane_valid.
  - Lanes that were not filled are driven to 0 in data_out.
  - out_strobe=1 for exactly one cycle.
  - data_out, lane_valid and partial hold their values until the next emission.
- busy = (state == FILL).

## Timing
- Reset (reset=0, asynchronous):
  - data_out=0, lane_valid=0, out_strobe=0, partial=0, busy=0.
  - ptr=0, idle counter=0, state IDLE.
- Release of reset is synchronised by the environment; the block takes no special action on release.
- Latency:
  - The symbol completing a word is sampled at edge t.
  - out_strobe and the new data_out are visible after edge t (registered, zero extra cycles).
- Throughput: one symbol per cycle sustained; back-to-back words produce out_strobe every LANES cycles with no bubble.
- Input gaps (valid_in=0) within a word are allowed. Lane order is preserved across gaps.
- Timeout: partial emission on the TIMEOUT-th consecutive idle edge after the last stored symbol.
- Reset mid-word: held symbols are discarded and no strobe is generated.

## Test plan
- Reset then 8 consecutive symbols 0x10..0x17 (LANES=4, WIDTH=8):
  - data_out=0x13121110 with strobe on the 4th edge.
  - data_out=0x17161514 with strobe on the 8th edge.
  - lane_valid=0xF and partial=0 both times.
- Symbols 0xA0, 0xA1, then flush with valid_in=0:
  - Single strobe, data_out=0x0000A1A0, lane_valid=0x3, partial=1, busy=0 next cycle.
- Flush together with the 4th symbol 0xD3 (after 0xD0..0xD2):
  - data_out=0xD3D2D1D0, lane_valid=0xF, partial=0, exactly one strobe.
- Timeout, TIMEOUT=8:
  - Symbol 0x55, then 7 idle cycles: no strobe.
  - 8th idle edge: strobe, data_out=0x00000055, lane_valid=0x1, partial=1.
  - Repeat with a symbol on idle cycle 7: timer restarts, no strobe at cycle 8.
- Async reset asserted after 3 symbols:
  - All outputs are 0 immediately; no strobe.
  - The next 4 symbols 0x01..0x04 yield data_out=0x04030201.
- Flush with valid_in=0 while IDLE:
  - No strobe; data_out, lane_valid and partial are unchanged.
